// File: rtl/ysyx_25040111_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter (IFU / LSU -> io_master AR/R).
// One single-beat read is in flight at a time. The response beat is held
// in a one-entry buffer until the owning master consumes it.
// Optional macro YSYX_25040111_ARB_RR_EN selects round-robin tie-breaking
// instead of fixed LSU priority.
module ysyx_25040111_rd_arbiter #(
  parameter int         AW       = 32,
  parameter int         DW       = 32,
  parameter logic [2:0] IFU_SIZE = 3'b010
) (
  input  logic          clk,
  input  logic          rst,
  // IFU read port
  input  logic          ifu_arvalid,
  output logic          ifu_arready,
  input  logic [AW-1:0] ifu_araddr,
  output logic          ifu_rvalid,
  input  logic          ifu_rready,
  output logic [DW-1:0] ifu_rdata,
  output logic [1:0]    ifu_rresp,
  // LSU read port
  input  logic          lsu_arvalid,
  output logic          lsu_arready,
  input  logic [AW-1:0] lsu_araddr,
  input  logic [2:0]    lsu_arsize,
  output logic          lsu_rvalid,
  input  logic          lsu_rready,
  output logic [DW-1:0] lsu_rdata,
  output logic [1:0]    lsu_rresp,
  // downstream read master
  output logic          m_arvalid,
  input  logic          m_arready,
  output logic [AW-1:0] m_araddr,
  output logic [2:0]    m_arsize,
  input  logic          m_rvalid,
  output logic          m_rready,
  input  logic [DW-1:0] m_rdata,
  input  logic [1:0]    m_rresp
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t        state_reg, state_next;
  logic          owner_reg;        // 0 = IFU, 1 = LSU
  logic [AW-1:0] addr_reg;
  logic [2:0]    size_reg;
  logic [DW-1:0] rdata_reg;
  logic [1:0]    rresp_reg;

  logic grant_lsu, grant_ifu;
  logic accept;
  logic resp_ready;

`ifdef YSYX_25040111_ARB_RR_EN
  logic last_grant_reg;            // 1 = LSU was granted last

  // Round-robin: on a tie the master not granted last wins.
  always_comb begin
    grant_lsu = lsu_arvalid & (~ifu_arvalid | ~last_grant_reg);
    grant_ifu = ifu_arvalid & ~grant_lsu;
  end

  // Remember the most recent winner for the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant_reg <= 1'b1;
    else if (accept) last_grant_reg <= grant_lsu;
  end
`else
  // Fixed priority: LSU beats IFU on a tie.
  always_comb begin
    grant_lsu = lsu_arvalid;
    grant_ifu = ifu_arvalid & ~lsu_arvalid;
  end
`endif

  // Requests are only accepted in IDLE; reset masks the combinational path too.
  assign ifu_arready = (state_reg == IDLE) & ~rst & grant_ifu;
  assign lsu_arready = (state_reg == IDLE) & ~rst & grant_lsu;
  assign accept      = ifu_arready | lsu_arready;

  assign m_arvalid  = (state_reg == ADDR);
  assign m_araddr   = addr_reg;
  assign m_arsize   = size_reg;
  assign m_rready   = (state_reg == DATA);

  assign ifu_rvalid = (state_reg == RESP) & ~owner_reg;
  assign lsu_rvalid = (state_reg == RESP) &  owner_reg;
  assign ifu_rdata  = rdata_reg;
  assign ifu_rresp  = rresp_reg;
  assign lsu_rdata  = rdata_reg;
  assign lsu_rresp  = rresp_reg;
  assign resp_ready = owner_reg ? lsu_rready : ifu_rready;

  // Next-state logic: walk one transaction through address, data, response.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)                 state_next = ADDR;
      ADDR:    if (m_arready)              state_next = DATA;
      DATA:    if (m_rvalid)               state_next = RESP;
      RESP:    if (resp_ready)             state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Latch the granted request; the downstream address stays stable until DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_reg <= 1'b0;
      addr_reg  <= '0;
      size_reg  <= '0;
    end else if (accept) begin
      owner_reg <= grant_lsu;
      addr_reg  <= grant_lsu ? lsu_araddr : ifu_araddr;
      size_reg  <= grant_lsu ? lsu_arsize : IFU_SIZE;
    end
  end

  // Response buffer: captured once in DATA, held through any back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_reg <= '0;
      rresp_reg <= '0;
    end else if ((state_reg == DATA) && m_rvalid) begin
      rdata_reg <= m_rdata;
      rresp_reg <= m_rresp;
    end
  end

endmodule
